// File: rtl/in_port_if.sv
// Link bundle between an upstream output port / switch allocator and the router input port.
// master drives flits and read selects; slave returns credits, dequeued flits and status.
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif

interface in_port_if #(
    parameter int VC_SIZE = 4
);
    logic [1:`FLIT_SIZE]  flit_in;
    logic                 flit_valid;
    logic [0:VC_SIZE-1]   credit;
    logic [0:VC_SIZE-1]   rd_vc;
    logic [1:`FLIT_SIZE]  flit_out;
    logic                 flit_out_valid;
    logic [0:VC_SIZE-1]   vc_not_empty;
    logic [0:VC_SIZE-1]   vc_head_ready;
    logic                 err_overflow;
    logic                 err_frame;

    modport master (
        output flit_in, flit_valid, rd_vc,
        input  credit, flit_out, flit_out_valid, vc_not_empty, vc_head_ready,
               err_overflow, err_frame
    );

    modport slave (
        input  flit_in, flit_valid, rd_vc,
        output credit, flit_out, flit_out_valid, vc_not_empty, vc_head_ready,
               err_overflow, err_frame
    );
endinterface

// File: rtl/in_port.sv
// Router input port: per-VC circular flit buffers fed by a credit-based link,
// one credit returned per dequeued flit, and per-VC packet framing checks.
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif

module in_port #(
    parameter int VC_SIZE   = 4,
    parameter int BUF_DEPTH = 4,
    parameter int VC_BITS   = 2
) (
    input logic         clk,
    input logic         rst,
    in_port_if.slave    link
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ACTIVE} frame_t;

    logic [1:`FLIT_SIZE]  mem [VC_SIZE][BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr [VC_SIZE];
    logic [PTR_W-1:0]     rd_ptr [VC_SIZE];
    logic [CNT_W-1:0]     cnt    [VC_SIZE];
    frame_t               state  [VC_SIZE];

    logic [0:VC_SIZE-1]   credit_p1;
    logic [1:`FLIT_SIZE]  flit_out_p1;
    logic                 vld_p1;
    logic                 err_overflow_p1;
    logic                 err_frame_p1;

    logic [VC_BITS-1:0]   wr_vc;
    logic [1:2]           wr_type;
    logic                 wr_vc_ok;
    logic                 wr_go;
    logic [VC_BITS-1:0]   rd_sel;
    logic                 rd_go;

    function automatic logic [VC_BITS-1:0] lowest_set(input logic [0:VC_SIZE-1] sel);
        logic [VC_BITS-1:0] idx;
        idx = '0;
        for (int i = VC_SIZE - 1; i >= 0; i--) begin
            if (sel[i]) idx = VC_BITS'(i);
        end
        return idx;
    endfunction

    // Write/read decode; a write into a full VC is only accepted when that VC is being read.
    always_comb begin
        wr_vc    = link.flit_in[3:2+VC_BITS];
        wr_type  = link.flit_in[1:2];
        wr_vc_ok = (int'(wr_vc) < VC_SIZE);
        rd_sel   = lowest_set(link.rd_vc);
        rd_go    = (|link.rd_vc) && (cnt[rd_sel] != '0);
        wr_go    = link.flit_valid && wr_vc_ok &&
                   ((cnt[wr_vc] != CNT_W'(BUF_DEPTH)) || (rd_go && (rd_sel == wr_vc)));
    end

    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_vc][wr_ptr[wr_vc]] <= link.flit_in;
    end

    // Stage p1: pointers, counts, framing state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_SIZE; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                cnt[v]    <= '0;
                state[v]  <= IDLE;
            end
            credit_p1       <= '0;
            flit_out_p1     <= '0;
            vld_p1          <= 1'b0;
            err_overflow_p1 <= 1'b0;
            err_frame_p1    <= 1'b0;
        end else begin
            credit_p1 <= '0;
            vld_p1    <= rd_go;
            if (rd_go) begin
                flit_out_p1       <= mem[rd_sel][rd_ptr[rd_sel]];
                credit_p1[rd_sel] <= 1'b1;
                rd_ptr[rd_sel]    <= rd_ptr[rd_sel] + 1'b1;
            end
            if (wr_go) wr_ptr[wr_vc] <= wr_ptr[wr_vc] + 1'b1;

            for (int v = 0; v < VC_SIZE; v++) begin
                case ({wr_go && (wr_vc == VC_BITS'(v)), rd_go && (rd_sel == VC_BITS'(v))})
                    2'b10:   cnt[v] <= cnt[v] + 1'b1;
                    2'b01:   cnt[v] <= cnt[v] - 1'b1;
                    default: cnt[v] <= cnt[v];
                endcase
            end

            if (link.flit_valid && wr_vc_ok && !wr_go) err_overflow_p1 <= 1'b1;

            // Framing tracks every arriving flit, including ones dropped for lack of space.
            if (link.flit_valid && wr_vc_ok) begin
                case (state[wr_vc])
                    IDLE: begin
                        if (wr_type == 2'b01) state[wr_vc] <= ACTIVE;
                        else if (wr_type != 2'b11) err_frame_p1 <= 1'b1;
                    end
                    ACTIVE: begin
                        if (wr_type == 2'b10) state[wr_vc] <= IDLE;
                        else if (wr_type[2]) err_frame_p1 <= 1'b1;
                    end
                    default: state[wr_vc] <= IDLE;
                endcase
            end
        end
    end

    // Status is decoded from registered buffer state; type bit 2 set means head or head+tail.
    always_comb begin
        for (int v = 0; v < VC_SIZE; v++) begin
            link.vc_not_empty[v]  = (cnt[v] != '0);
            link.vc_head_ready[v] = (cnt[v] != '0) && mem[v][rd_ptr[v]][2];
        end
    end

    assign link.credit         = credit_p1;
    assign link.flit_out       = flit_out_p1;
    assign link.flit_out_valid = vld_p1;
    assign link.err_overflow   = err_overflow_p1;
    assign link.err_frame      = err_frame_p1;

endmodule
